// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: operand width, func3 encodings, FSM states.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply, or restoring divide when
// EX_MULDIV_DIV_EN is defined. {hi,lo} is the product accumulator or {remainder,quotient}.
module muldiv_step
  import muldiv_pkg::*;
(
`ifdef EX_MULDIV_DIV_EN
  input  logic            is_div,
`endif
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
`ifdef EX_MULDIV_DIV_EN
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            diff_unused;
  // A non-negative trial difference always fits back into XLEN bits.
  assign diff_unused = diff[XLEN];
`endif

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    hi_nxt = sum[XLEN:1];
    lo_nxt = {sum[0], lo[XLEN-1:1]};
`ifdef EX_MULDIV_DIV_EN
    shifted = {hi, lo[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, b};
    if (is_div) begin
      hi_nxt = diff[XLEN+1] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ~diff[XLEN+1]};
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M execute unit: 32 RUN cycles per operation, signs fixed up on the last step.
// Divide support is built only when EX_MULDIV_DIV_EN is defined; otherwise divides return 0.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            is_m,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);
  import muldiv_pkg::*;

  state_t            state, state_nxt;
  logic [4:0]        cnt;
  logic [XLEN-1:0]   hi_r, lo_r, b_r, result_r;
  logic [2:0]        op_r;
  logic              neg_r;
  logic              accept, a_sgn, b_sgn, a_neg, b_neg, neg_in, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, hi_nxt, lo_nxt, final_res;
  logic [2*XLEN-1:0] prod;
`ifdef EX_MULDIV_DIV_EN
  logic [XLEN-1:0]   div_val;
`endif

  assign accept       = (state == S_IDLE) && valid_in && is_m && !flush;
  assign busy         = (state == S_RUN) || accept;
  assign result_valid = (state == S_DONE) && !flush;
  assign result       = result_r;
  assign dbg_state    = state;

  // Operand signedness and magnitudes, captured on accept.
  always_comb begin
    if (func3[2]) begin
      a_sgn = ~func3[0];
      b_sgn = ~func3[0];
    end else begin
      a_sgn = (func3 == F3_MULH) || (func3 == F3_MULHSU);
      b_sgn = (func3 == F3_MULH);
    end
    a_neg  = a_sgn && op1[XLEN-1];
    b_neg  = b_sgn && op2[XLEN-1];
    a_mag  = a_neg ? -op1 : op1;
    b_mag  = b_neg ? -op2 : op2;
    // Remainder follows the dividend; product and quotient follow the sign product.
    neg_in = (func3[2] && func3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
`ifdef EX_MULDIV_DIV_EN
    special     = func3[2] && ((op2 == '0) ||
                  (!func3[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1)));
    if (op2 == '0) special_res = func3[1] ? op1 : '1;
    else           special_res = func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`else
    special     = func3[2];
    special_res = '0;
`endif
  end

  muldiv_step u_step (
`ifdef EX_MULDIV_DIV_EN
    .is_div (op_r[2]),
`endif
    .hi     (hi_r),
    .lo     (lo_r),
    .b      (b_r),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_comb begin
    prod      = {hi_nxt, lo_nxt};
    if (neg_r) prod = -prod;
    final_res = (op_r == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef EX_MULDIV_DIV_EN
    div_val   = op_r[1] ? hi_nxt : lo_nxt;
    if (op_r[2]) final_res = neg_r ? -div_val : div_val;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = special ? S_DONE : S_RUN;
      S_RUN:   if (flush) state_nxt = S_IDLE;
               else if (cnt == 5'd31) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      b_r      <= '0;
      op_r     <= '0;
      neg_r    <= 1'b0;
      result_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        hi_r  <= '0;
        lo_r  <= a_mag;
        b_r   <= b_mag;
        op_r  <= func3;
        neg_r <= neg_in;
        cnt   <= '0;
        if (special) result_r <= special_res;
      end else if (state == S_RUN) begin
        hi_r <= hi_nxt;
        lo_r <= lo_nxt;
        cnt  <= flush ? 5'd0 : cnt + 5'd1;
        if ((cnt == 5'd31) && !flush) result_r <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        is_m = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        busy, result_valid;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .is_m         (is_m),
    .func3        (func3),
    .op1          (op1),
    .op2          (op2),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: begin
`ifdef EX_MULDIV_DIV_EN
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return f3[1] ? 32'd0 : 32'h8000_0000;
        case (f3)
          3'd4:    return ia / ib;
          3'd5:    return a / b;
          3'd6:    return ia % ib;
          default: return a % b;
        endcase
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f3[2]) return 33;
`ifdef EX_MULDIV_DIV_EN
    if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  // Issue one operation, hold scrambled valid_in traffic while it runs, then check it.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat, exp_lat;
    logic run_busy_ok;
    logic [31:0] exp_r;
    @(negedge clk);
    func3 = f3; op1 = a; op2 = b; valid_in = 1'b1; is_m = 1'b1;
    #1 check("busy_accept", {31'd0, busy}, 32'd1);
    exp_q.push_back(ref_result(f3, a, b));
    exp_lat = ref_latency(f3, a, b);
    @(posedge clk);
    lat = 0;
    run_busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      op1 = $urandom; op2 = $urandom; func3 = 3'($urandom_range(0, 7));
      #1;
      if (result_valid) begin
        lat = k;
        break;
      end
      if (!busy) run_busy_ok = 1'b0;
    end
    valid_in = 1'b0; is_m = 1'b0;
    check("latency", lat, exp_lat);
    check("busy_run", {31'd0, run_busy_ok}, 32'd1);
    exp_r = exp_q.pop_front();
    if (lat != 0) begin
      check("result", result, exp_r);
      check("busy_done", {31'd0, busy}, 32'd0);
      last_result = exp_r;
      @(negedge clk);
      #1 check("pulse_end", {31'd0, result_valid}, 32'd0);
      check("result_hold", result, exp_r);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen_valid;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, result_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul_7_m3", last_result, 32'hFFFF_FFEB);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd5, 32'd5, 32'd0);
    do_op(3'd7, 32'd5, 32'd0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd4, 32'd9, 32'd3);
    do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);

    // Flush on RUN cycle 10, then a new MUL the cycle after busy drops.
    @(negedge clk);
    func3 = 3'd0; op1 = 32'd100; op2 = 32'd3; valid_in = 1'b1; is_m = 1'b1;
    @(posedge clk);
    seen_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      valid_in = 1'b0; is_m = 1'b0;
      if (k == 10) flush = 1'b1;
      #1 if (result_valid) seen_valid++;
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_no_valid", seen_valid + {31'd0, result_valid}, 32'd0);
    check("flush_result_hold", result, last_result);
    do_op(3'd0, 32'd6, 32'd7);

    // Flush in IDLE and is_m=0 both block accept.
    @(negedge clk);
    valid_in = 1'b1; is_m = 1'b1; flush = 1'b1;
    #1 check("idle_flush_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    flush = 1'b0; is_m = 1'b0;
    #1 check("non_m_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    #1 check("blocked_state", {30'd0, dbg_state}, 32'd0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    func3 = 3'd0; op1 = 32'd11; op2 = 32'd13; valid_in = 1'b1; is_m = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    valid_in = 1'b0; is_m = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_valid", {31'd0, result_valid}, 32'd0);
    check("rst_run_result", result, 32'd0);
    check("rst_run_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++)
      do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have valid_in  input  1  execute-stage instruction valid this cycle.
REQ-005 SHALL have is_m  input  1  instruction is RV32M (opcode 0110011, funct7 0000001).
REQ-006 SHALL have func3  input  3  RV32M operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have op1, op2  input  32 each  forwarded operands from the operand-select stage.
REQ-008 SHALL have flush  input  1  kill in-flight operation on branch/jump redirect.
REQ-009 SHALL have busy  output  1  pipeline stall request to upstream stages.
REQ-010 SHALL have result_valid  output  1  one-cycle pulse marking result valid.
REQ-011 SHALL have result  output  32  product/quotient/remainder, toward exdata.

Function
REQ-012 SHALL have states IDLE, RUN, DONE.
REQ-013 SHALL accept an operation when state is IDLE, valid_in=1, is_m=1 and flush=0; operands, func3 and sign flags are latched at that edge.
REQ-014 SHALL compute busy combinationally: 1 in RUN, and 1 in IDLE while an accept condition holds; 0 in DONE.
REQ-015 SHALL, on accept, enter RUN with a 5-bit step counter at 0, except for special divide cases (REQ-019, REQ-020), which go directly to DONE.
REQ-016 SHALL perform one radix-2 shift-add (multiply) or restoring-subtract (divide) step per RUN cycle, on magnitudes with sign correction applied at the end; RUN lasts exactly 32 cycles, then DONE.
REQ-017 SHALL assert result_valid and drive result only in DONE, for exactly one cycle, then return to IDLE; result holds its value until the next DONE.
REQ-018 SHALL return low 32 bits of the 64-bit product for MUL; high 32 bits for MULH (s x s), MULHSU (s x u), MULHU (u x u).
REQ-019 SHALL, when the divisor is 0, return all-ones for DIV/DIVU and op1 for REM/REMU, with result_valid one cycle after accept.
REQ-020 SHALL, for DIV/REM with op1=0x80000000 and op2=0xFFFFFFFF, return 0x80000000 (DIV) or 0 (REM), one cycle after accept.
REQ-021 SHALL round signed quotients toward zero; a signed remainder takes the sign of the dividend.
REQ-022 SHALL, on flush in RUN or DONE, go to IDLE at the next edge with no result_valid pulse; flush in IDLE blocks the accept.
REQ-023 SHALL ignore valid_in while in RUN or DONE; back-to-back operations require a return to IDLE.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, counter 0, busy 0, result_valid 0, result 0x00000000, regardless of any operation in progress.

Configuration
REQ-025 SHALL compile the divide datapath only when macro EX_MULDIV_DIV_EN is defined.
REQ-026 SHALL, without EX_MULDIV_DIV_EN, treat func3[2]=1 as accepted and go directly to DONE, returning result 0 one cycle after accept; multiply behaviour is unchanged.

Structure
REQ-027 SHALL place the func3 encodings, the state enumeration and the XLEN constant in shared package muldiv_pkg.
REQ-028 SHALL implement the per-cycle add/subtract step in one sub-module, muldiv_step; sign handling and the FSM stay in ex_muldiv.

Verification
REQ-029 SHALL cover: MUL op1=7, op2=0xFFFFFFFD -> result 0xFFFFFFEB, result_valid 33 cycles after accept, busy high throughout.
REQ-030 SHALL cover: MULHU op1=op2=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-031 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in 1 cycle; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-032 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF, each after 33 cycles.
REQ-033 SHALL cover: flush on RUN cycle 10 -> no result_valid, busy 0 next cycle, new MUL accepted the cycle after.
REQ-034 SHALL cover: rst_n low mid-RUN -> all outputs 0 immediately; build without EX_MULDIV_DIV_EN: DIV 9/3 -> 0 after 1 cycle.
